enc_store_ctrl: RTL
===================

# enc_store_ctrl

Sequencing controller for the encrypt-and-store datapath: number register, rotator, 4x4 multiplier, 4-to-16 address decoder and 16 x 8 store memory. It accepts one (num, key) job per valid/ready handshake and drives the enables in order: register load, rotate, multiply settle, memory write. It also keeps a 16-entry written-entry map. It replaces the free-running always-enabled control in the current datapath top.

## Interface
- ROT_STEPS, default 1: cycles rot_en is held per job; legal range 1..3.
- NUM_W, default 4: width of num/key; the product is 2*NUM_W.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  job request.
- in_ready  out  1  controller can accept a job.
- in_num  in  NUM_W  number; also the store address.
- in_key  in  NUM_W  multiplier key.
- clr  in  1  one-cycle pulse; clears valid_map.
- reg_en  out  1  load enable for the number register.
- rot_en  out  1  rotator enable.
- num_q  out  NUM_W  captured number, to the register input.
- key_q  out  NUM_W  captured key, to the multiplier.
- mem_we  out  1  store-memory write enable.
- mem_addr  out  2**NUM_W  one-hot write address.
- busy  out  1  a job is in flight.
- done  out  1  one-cycle pulse when a job completes.
- err  out  1  one-cycle pulse when a write is blocked (only with the macro).
- valid_map  out  2**NUM_W  bit i = entry i has been written.

## Operation
- FSM states: IDLE, LOAD, ROTATE, SETTLE, WRITE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture num_q/key_q and go to LOAD.
- LOAD: reg_en=1 for one cycle, then ROTATE.
- ROTATE:
  - rot_en=1 for exactly ROT_STEPS cycles, counted by an internal down-counter.
  - Then SETTLE.
- SETTLE: one idle cycle for the combinational multiplier; then WRITE.
- WRITE:
  - mem_we=1 and mem_addr=one-hot(num_q) for one cycle.
  - Sets valid_map[num_q]; then DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- num_q and key_q hold their values until the next accept.
- in_valid outside IDLE is ignored; the requester holds in_valid and the inputs until in_ready.
- mem_addr is all-zero whenever mem_we=0.
- clr in the same cycle as a WRITE: the whole map clears, then the written bit is set (the write wins).
- Reset, including mid-job:
  - State goes to IDLE and the job is abandoned with no write and no done.
  - All outputs go to 0, except in_ready=1 in the cycle after reset.
  - valid_map=0, num_q=0, key_q=0.

## Timing
- Accept at edge k. LOAD occupies cycle k+1, ROTATE k+2..k+1+ROT_STEPS, SETTLE k+2+ROT_STEPS, WRITE k+3+ROT_STEPS, DONE k+4+ROT_STEPS.
- Accept to done latency is ROT_STEPS+4 cycles: 5 for the default.
- Job throughput is one job per ROT_STEPS+5 cycles, because IDLE costs one cycle.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.

## Configuration
- Macro ENC_STORE_CTRL_WRITE_PROTECT_EN.
- Defined:
  - In WRITE, if valid_map[num_q]=1, mem_we stays 0 and err pulses for that cycle.
  - DONE still follows.
  - A clr in the same cycle does not unblock the write; the check uses the pre-clear map.
- Undefined: overwrites are always allowed and err is tied to 0.

## Structure
- The shared package enc_pkg holds:
  - The state enum enc_state_t.
  - NUM_W and the legal ROT_STEPS bounds.
  - A one-hot decode function.
- Sub-module enc_store_scoreboard holds valid_map: the set, clear and check logic, and the write-protect decision under the macro.
- The FSM and the rotate counter stay in the top module.

## Test plan
- Reset, then in_num=8, in_key=8 with ROT_STEPS=1 -> reg_en@k+1, rot_en@k+2, mem_we with mem_addr=16'h0100@k+4, done@k+5, valid_map=16'h0100.
- in_valid held high with back-to-back jobs num=9 then num=12 -> second accept exactly 6 cycles after the first; valid_map=16'h1200 after both.
- ROT_STEPS=3 -> rot_en high for exactly 3 consecutive cycles; done 7 cycles after accept.
- Reset asserted during ROTATE -> no mem_we, no done; next cycle in_ready=1, busy=0, valid_map=0.
- clr during WRITE of num=11 -> valid_map=16'h0800 afterwards.
- Macro defined, num=11 written twice -> second job has mem_we=0 and an err pulse in the WRITE cycle, then done. Macro undefined -> second write proceeds and err stays 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types for the encrypt-and-store controller: FSM state enum,
// number width, legal rotate-step bounds and the one-hot address decode.
package enc_pkg;

  localparam int ENC_NUM_W = 4;
  localparam int ENC_MAP_W = 1 << ENC_NUM_W;
  localparam int ROT_MIN   = 1;
  localparam int ROT_MAX   = 3;
  localparam int ROT_CNT_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROTATE,
    SETTLE,
    WRITE,
    DONE
  } enc_state_t;

  function automatic logic [ENC_MAP_W-1:0] onehot(
    input logic [ENC_NUM_W-1:0] idx
  );
    logic [ENC_MAP_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/enc_store_scoreboard.sv
// Written-entry map for the store memory: set on write, clear on clr,
// and (with ENC_STORE_CTRL_WRITE_PROTECT_EN) block writes to written entries.
// Ports: clk_i, reset_i, clr_i, wr_i (WRITE state), idx_i (entry),
//        map_o (valid map), blocked_o (write suppressed this cycle).
module enc_store_scoreboard
  import enc_pkg::*;
#(
  parameter int NUM_W = ENC_NUM_W
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clr_i,
  input  logic                    wr_i,
  input  logic [NUM_W-1:0]        idx_i,
  output logic [(1<<NUM_W)-1:0]   map_o,
  output logic                    blocked_o
);

  logic [(1<<NUM_W)-1:0] map_q;
  logic [(1<<NUM_W)-1:0] map_d;

`ifdef ENC_STORE_CTRL_WRITE_PROTECT_EN
  // Decided on the pre-clear map, so a same-cycle clr cannot unblock.
  assign blocked_o = map_q[idx_i];
`else
  assign blocked_o = 1'b0;
`endif

  // Clear first, then set: a write in the clr cycle survives.
  always_comb begin
    map_d = clr_i ? '0 : map_q;
    if (wr_i && !blocked_o) begin
      map_d = map_d | onehot(idx_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      map_q <= '0;
    end else begin
      map_q <= map_d;
    end
  end

  assign map_o = map_q;

endmodule

// File: rtl/enc_store_ctrl.sv
// Sequencer for the encrypt-and-store datapath: load, rotate, settle, write.
// Ports: clk, reset, in_valid/in_ready/in_num/in_key job handshake, clr,
//        reg_en, rot_en, num_q, key_q, mem_we, mem_addr, busy, done, err,
//        valid_map. Optional macro: ENC_STORE_CTRL_WRITE_PROTECT_EN.
module enc_store_ctrl
  import enc_pkg::*;
#(
  parameter int ROT_STEPS = 1,
  parameter int NUM_W     = ENC_NUM_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_W-1:0]      in_num,
  input  logic [NUM_W-1:0]      in_key,
  input  logic                  clr,
  output logic                  reg_en,
  output logic                  rot_en,
  output logic [NUM_W-1:0]      num_q,
  output logic [NUM_W-1:0]      key_q,
  output logic                  mem_we,
  output logic [(1<<NUM_W)-1:0] mem_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [(1<<NUM_W)-1:0] valid_map
);

  // Out-of-range step counts are clamped to the legal window.
  localparam int ROT_N = (ROT_STEPS < ROT_MIN) ? ROT_MIN :
                         (ROT_STEPS > ROT_MAX) ? ROT_MAX : ROT_STEPS;

  enc_state_t           state_q, state_d;
  logic [ROT_CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0]     num_d, key_d;
  logic                 wr;
  logic                 blocked;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    key_d   = key_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          num_d   = in_num;
          key_d   = in_key;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = ROT_CNT_W'(ROT_N - 1);
        state_d = ROTATE;
      end
      ROTATE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE:  state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      key_q   <= key_d;
    end
  end

  assign wr       = (state_q == WRITE);
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign reg_en   = (state_q == LOAD);
  assign rot_en   = (state_q == ROTATE);
  assign done     = (state_q == DONE);
  assign mem_we   = wr && !blocked;
  assign err      = wr && blocked;
  assign mem_addr = mem_we ? onehot(num_q) : '0;

  enc_store_scoreboard #(
    .NUM_W (NUM_W)
  ) u_sb (
    .clk_i     (clk),
    .reset_i   (reset),
    .clr_i     (clr),
    .wr_i      (wr),
    .idx_i     (num_q),
    .map_o     (valid_map),
    .blocked_o (blocked)
  );

endmodule
